mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter sharing the single 16-bit-data / 24-bit-address memory port between the CPU core (port A) and a secondary master such as a DMA or display reader (port B). It sits between the requesters and the memory. It grants one access at a time and tracks the outstanding read until its data returns after a fixed read latency. When port A is uncontested, a grant is issued in the same cycle as the request, so the core sees unchanged single-cycle address-to-data timing.

## Interface
- ADDR_W, 24, address width
- DATA_W, 16, data width
- RD_LATENCY, 1, cycles from address presented to `mem_rdata` valid; legal range 1..4
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `a_req`, `b_req`  in  1  access request; held with its qualifiers until granted
- `a_we`, `b_we`  in  1  1 = write, 0 = read
- `a_addr`, `b_addr`  in  ADDR_W  access address
- `a_wdata`, `b_wdata`  in  DATA_W  write data
- `a_gnt`, `b_gnt`  out  1  combinational; access issued to memory this cycle
- `a_rvalid`, `b_rvalid`  out  1  registered; read data valid this cycle, one pulse per granted read
- `a_rdata`, `b_rdata`  out  DATA_W  passthrough of `mem_rdata`
- `mem_addr`  out  ADDR_W  address to memory
- `mem_wdata`  out  DATA_W  write data to memory
- `mem_we`  out  1  memory write enable
- `mem_rdata`  in  DATA_W  read data from memory
- `busy`  out  1  read outstanding; no grant possible this cycle

## Operation
- States: IDLE, WAIT. The reset state is IDLE with the latency counter at 0 and `last` = B.
- A grant is possible only in IDLE, or in the WAIT cycle where the counter expires (the "free cycle").
- In a grant-possible cycle, the winner among the asserted requests is chosen. Its `gnt` is raised, and `mem_addr`/`mem_wdata`/`mem_we` are driven from its inputs in the same cycle.
- In a non-grant cycle, `mem_we` = 0 and `mem_addr`/`mem_wdata` = 0.
- Write grant: the access completes in the grant cycle. The next state is IDLE, and no `rvalid` is produced.
- Read grant: the owner and the counter = RD_LATENCY are recorded.
  - With RD_LATENCY = 1, the next cycle is the free cycle.
  - Otherwise the block enters WAIT with `busy` = 1 and decrements the counter each cycle.
- Free cycle: the owner's `rvalid` = 1 with `rdata` = `mem_rdata`, and a new grant may be issued in the same cycle. Back-to-back reads therefore sustain 1 access/cycle at RD_LATENCY = 1.
- A requester must not deassert or change `req`, `we`, `addr` or `wdata` before `gnt`. It may issue its next request in the cycle after `gnt`.
- Both `rvalid` outputs are never high together. `gnt` is never high on both ports together.
- Reset mid-operation: an outstanding read is discarded with no `rvalid`, and the block returns to IDLE at once.

## Timing
- Uncontested read: `gnt` in cycle t, `rvalid` in cycle t+RD_LATENCY.
- Uncontested write: `gnt` and `mem_we` in cycle t.
- While `rst` = 1: `a_gnt` = `b_gnt` = 0, `a_rvalid` = `b_rvalid` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `busy` = 0.
- `rdata` outputs always follow `mem_rdata`. They are meaningful only when the matching `rvalid` = 1.
- The worst-case wait for a held request is RD_LATENCY cycles with round-robin. With fixed priority, port B's wait is unbounded.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - A single requester always wins.
  - On a tie, the port other than `last` wins.
  - `last` updates to the winner on every grant.
- `MEM_ARB_RR_EN` undefined: fixed priority. Port A wins every tie, B is granted only when `a_req` = 0, and `last` is unused.

## Test plan
- Reset: hold `rst` = 1 with `a_req` = `b_req` = 1 → both `gnt` = 0, `mem_we` = 0, `mem_addr` = 0. Release → A granted first in either configuration.
- Uncontested A read: `a_addr` = 0x004000, memory returns 0xBEEF at RD_LATENCY = 1 → `a_gnt` in cycle t, `a_rvalid` = 1 with `a_rdata` = 0xBEEF in t+1, `b_rvalid` = 0.
- B write: `b_we` = 1, `b_addr` = 0x000010, `b_wdata` = 0x1234, `a_req` = 0 → `mem_we` = 1, `mem_addr` = 0x000010, `mem_wdata` = 0x1234 in the grant cycle, and no `rvalid`.
- Contention, both reads held for 4 grants at RD_LATENCY = 1:
  - with `MEM_ARB_RR_EN`, the grant order is A, B, A, B;
  - without it, the order is A, A, A, A while `a_req` is held.
- RD_LATENCY = 3 read by A at cycle t with `b_req` raised at t+1 → `busy` = 1 in t+1..t+2, `a_rvalid` and `b_gnt` both in t+3.
- Reset asserted in cycle t+1 of an RD_LATENCY = 3 read → no `a_rvalid` ever; after release, a new A read completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: both requester ports, the shared memory port and busy.
// The slave modport is the arbiter; the master modport is the requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  mem_rdata,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_addr, mem_wdata, mem_we, busy
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output mem_rdata,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_addr, mem_wdata, mem_we, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for a single memory port with fixed read latency (1..4 cycles).
// Define MEM_ARB_RR_EN for round-robin ties; otherwise port A has fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 1
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  state_t            state, state_next;
  logic [2:0]        cnt, cnt_next;
  logic              owner_b, owner_b_next;
  logic              free, can_grant, a_wins, pick_a, pick_b, grant_we;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;
`ifdef MEM_ARB_RR_EN
  logic              last_b, last_b_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      owner_b <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      owner_b <= owner_b_next;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_b <= 1'b1;
    else     last_b <= last_b_next;
  end
`endif

  // The free cycle both returns the owner's data and may issue the next grant.
  always_comb begin
    free      = (state == WAIT) && (cnt == 3'd1);
    can_grant = !rst && ((state == IDLE) || free);
`ifdef MEM_ARB_RR_EN
    a_wins    = bus.a_req && (!bus.b_req || last_b);
`else
    a_wins    = bus.a_req;
`endif
    pick_a    = can_grant && a_wins;
    pick_b    = can_grant && bus.b_req && !a_wins;
    grant_we  = pick_a ? bus.a_we : bus.b_we;

    addr_mux  = '0;
    wdata_mux = '0;
    if (pick_a) begin
      addr_mux  = bus.a_addr;
      wdata_mux = bus.a_wdata;
    end else if (pick_b) begin
      addr_mux  = bus.b_addr;
      wdata_mux = bus.b_wdata;
    end

    state_next   = state;
    cnt_next     = cnt;
    owner_b_next = owner_b;
`ifdef MEM_ARB_RR_EN
    last_b_next  = last_b;
`endif
    if (pick_a || pick_b) begin
`ifdef MEM_ARB_RR_EN
      last_b_next = pick_b;
`endif
      if (grant_we) begin
        state_next = IDLE;
        cnt_next   = 3'd0;
      end else begin
        state_next   = WAIT;
        cnt_next     = LAT;
        owner_b_next = pick_b;
      end
    end else if (free) begin
      state_next = IDLE;
      cnt_next   = 3'd0;
    end else if (state == WAIT) begin
      cnt_next = cnt - 3'd1;
    end
  end

  assign bus.a_gnt     = pick_a;
  assign bus.b_gnt     = pick_b;
  assign bus.mem_we    = (pick_a || pick_b) && grant_we;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.a_rvalid  = free && !owner_b;
  assign bus.b_rvalid  = free && owner_b;
  assign bus.busy      = (state == WAIT) && !free;
  assign bus.a_rdata   = bus.mem_rdata;
  assign bus.b_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: one instance at RD_LATENCY=1 and one at 3,
// each shadowed every cycle by a due-time model of the arbitration rules.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle    = 0;

  mem_port_arbiter_if #(.ADDR_W(24), .DATA_W(16)) if1 ();
  mem_port_arbiter_if #(.ADDR_W(24), .DATA_W(16)) if3 ();

  mem_port_arbiter #(.ADDR_W(24), .DATA_W(16), .RD_LATENCY(1)) u_l1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  mem_port_arbiter #(.ADDR_W(24), .DATA_W(16), .RD_LATENCY(3)) u_l3 (
    .clk (clk),
    .rst (rst),
    .bus (if3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        a_req, b_req, a_we, b_we;
    logic [23:0] a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata, mem_rdata;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid, mem_we, busy;
    logic [23:0] mem_addr;
    logic [15:0] mem_wdata, a_rdata, b_rdata;
  } snap_t;

  // Model state per instance: one outstanding read due at an absolute cycle.
  bit m_pending[2] = '{0, 0};
  int m_due[2]     = '{0, 0};
  bit m_owner_b[2] = '{0, 0};
  bit m_last_b[2]  = '{1, 1};
  int m_lat[2]     = '{1, 3};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic modelCheck(input int d, input snap_t s);
    string       p;
    bit          rv_now, free, tie_b, pick_b, any;
    logic        ea_gnt, eb_gnt, ea_rv, eb_rv, e_busy, e_we;
    logic [23:0] e_addr;
    logic [15:0] e_wdata;
    p = (d == 0) ? "L1" : "L3";
    ea_gnt = 0; eb_gnt = 0; ea_rv = 0; eb_rv = 0; e_busy = 0; e_we = 0;
    e_addr = '0; e_wdata = '0;
    if (rst) begin
      m_pending[d] = 0;
      m_last_b[d]  = 1;
    end else begin
      rv_now = m_pending[d] && (m_due[d] == cycle);
      ea_rv  = rv_now && !m_owner_b[d];
      eb_rv  = rv_now && m_owner_b[d];
      e_busy = m_pending[d] && !rv_now;
      free   = !e_busy;
`ifdef MEM_ARB_RR_EN
      tie_b  = !m_last_b[d];
`else
      tie_b  = 0;
`endif
      pick_b = (s.a_req && s.b_req) ? tie_b : s.b_req;
      any    = free && (s.a_req || s.b_req);
      if (any) begin
        ea_gnt  = !pick_b;
        eb_gnt  = pick_b;
        e_we    = pick_b ? s.b_we : s.a_we;
        e_addr  = pick_b ? s.b_addr : s.a_addr;
        e_wdata = pick_b ? s.b_wdata : s.a_wdata;
      end
      if (rv_now) m_pending[d] = 0;
      if (any) begin
        m_last_b[d] = pick_b;
        if (!e_we) begin
          m_pending[d] = 1;
          m_due[d]     = cycle + m_lat[d];
          m_owner_b[d] = pick_b;
        end
      end
    end
    checkOutput({p, "_a_gnt"}, 32'(s.a_gnt), 32'(ea_gnt));
    checkOutput({p, "_b_gnt"}, 32'(s.b_gnt), 32'(eb_gnt));
    checkOutput({p, "_a_rvalid"}, 32'(s.a_rvalid), 32'(ea_rv));
    checkOutput({p, "_b_rvalid"}, 32'(s.b_rvalid), 32'(eb_rv));
    checkOutput({p, "_busy"}, 32'(s.busy), 32'(e_busy));
    checkOutput({p, "_mem_we"}, 32'(s.mem_we), 32'(e_we));
    checkOutput({p, "_mem_addr"}, 32'(s.mem_addr), 32'(e_addr));
    checkOutput({p, "_mem_wdata"}, 32'(s.mem_wdata), 32'(e_wdata));
    if (ea_rv) checkOutput({p, "_a_rdata"}, 32'(s.a_rdata), 32'(s.mem_rdata));
    if (eb_rv) checkOutput({p, "_b_rdata"}, 32'(s.b_rdata), 32'(s.mem_rdata));
  endtask

  // Compare both instances against the model once per cycle, away from the rising edge.
  always @(negedge clk) begin
    snap_t s1, s3;
    s1 = '{if1.a_req, if1.b_req, if1.a_we, if1.b_we, if1.a_addr, if1.b_addr,
           if1.a_wdata, if1.b_wdata, if1.mem_rdata, if1.a_gnt, if1.b_gnt,
           if1.a_rvalid, if1.b_rvalid, if1.mem_we, if1.busy, if1.mem_addr,
           if1.mem_wdata, if1.a_rdata, if1.b_rdata};
    s3 = '{if3.a_req, if3.b_req, if3.a_we, if3.b_we, if3.a_addr, if3.b_addr,
           if3.a_wdata, if3.b_wdata, if3.mem_rdata, if3.a_gnt, if3.b_gnt,
           if3.a_rvalid, if3.b_rvalid, if3.mem_we, if3.busy, if3.mem_addr,
           if3.mem_wdata, if3.a_rdata, if3.b_rdata};
    modelCheck(0, s1);
    modelCheck(1, s3);
    cycle++;
  end

  task automatic applyStimulus(input int d,
                               input logic a_req, input logic a_we, input logic [23:0] a_addr, input logic [15:0] a_wdata,
                               input logic b_req, input logic b_we, input logic [23:0] b_addr, input logic [15:0] b_wdata,
                               input logic [15:0] mem_rdata);
    if (d == 0) begin
      if1.a_req = a_req; if1.a_we = a_we; if1.a_addr = a_addr; if1.a_wdata = a_wdata;
      if1.b_req = b_req; if1.b_we = b_we; if1.b_addr = b_addr; if1.b_wdata = b_wdata;
      if1.mem_rdata = mem_rdata;
    end else begin
      if3.a_req = a_req; if3.a_we = a_we; if3.a_addr = a_addr; if3.a_wdata = a_wdata;
      if3.b_req = b_req; if3.b_we = b_we; if3.b_addr = b_addr; if3.b_wdata = b_wdata;
      if3.mem_rdata = mem_rdata;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit order_q[$];
    bit exp_order[5];
    bit a_last, b_last;
`ifdef MEM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1, 0};
`else
    exp_order = '{0, 0, 0, 0, 1};
`endif
    rst = 1'b0;
    applyStimulus(0, 1, 0, 24'h000100, 16'h0, 1, 0, 24'h000200, 16'h0, 16'h1111);
    applyStimulus(1, 0, 0, 24'h0, 16'h0, 0, 0, 24'h0, 16'h0, 16'h0);
    #1 rst = 1'b1;

    // Reset with both requests pending: nothing may be granted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_a_gnt", 32'(if1.a_gnt), 32'd0);
    checkOutput("rst_b_gnt", 32'(if1.b_gnt), 32'd0);
    checkOutput("rst_mem_we", 32'(if1.mem_we), 32'd0);
    checkOutput("rst_mem_addr", 32'(if1.mem_addr), 32'd0);

    step();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("first_gnt_a", 32'(if1.a_gnt), 32'd1);
    checkOutput("first_gnt_b", 32'(if1.b_gnt), 32'd0);

    // Contention: each port re-requests after its grant until four grants have gone out.
    a_last = if1.a_gnt;
    b_last = if1.b_gnt;
    if (a_last) order_q.push_back(1'b0);
    if (b_last) order_q.push_back(1'b1);
    for (int c = 0; c < 20 && (if1.a_req || if1.b_req); c++) begin
      step();
      if (a_last) if1.a_req = (order_q.size() < 4);
      if (b_last) if1.b_req = (order_q.size() < 4);
      @(negedge clk);
      a_last = if1.a_gnt;
      b_last = if1.b_gnt;
      if (a_last) order_q.push_back(1'b0);
      if (b_last) order_q.push_back(1'b1);
    end
    checkOutput("contention_drained", 32'(if1.a_req || if1.b_req), 32'd0);
    checkOutput("grant_count", 32'(order_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < order_q.size()) checkOutput($sformatf("grant_order_%0d", i), 32'(order_q[i]), 32'(exp_order[i]));
    end
    repeat (2) step();

    // Uncontested A read at latency 1.
    applyStimulus(0, 1, 0, 24'h004000, 16'h0, 0, 0, 24'h0, 16'h0, 16'h0000);
    @(negedge clk);
    checkOutput("rd_a_gnt", 32'(if1.a_gnt), 32'd1);
    checkOutput("rd_mem_addr", 32'(if1.mem_addr), 32'h004000);
    step();
    applyStimulus(0, 0, 0, 24'h0, 16'h0, 0, 0, 24'h0, 16'h0, 16'hBEEF);
    @(negedge clk);
    checkOutput("rd_a_rvalid", 32'(if1.a_rvalid), 32'd1);
    checkOutput("rd_a_rdata", 32'(if1.a_rdata), 32'h0000BEEF);
    checkOutput("rd_b_rvalid", 32'(if1.b_rvalid), 32'd0);

    // B write while A idle.
    step();
    applyStimulus(0, 0, 0, 24'h0, 16'h0, 1, 1, 24'h000010, 16'h1234, 16'hBEEF);
    @(negedge clk);
    checkOutput("wr_b_gnt", 32'(if1.b_gnt), 32'd1);
    checkOutput("wr_mem_we", 32'(if1.mem_we), 32'd1);
    checkOutput("wr_mem_addr", 32'(if1.mem_addr), 32'h000010);
    checkOutput("wr_mem_wdata", 32'(if1.mem_wdata), 32'h00001234);
    step();
    applyStimulus(0, 0, 0, 24'h0, 16'h0, 0, 0, 24'h0, 16'h0, 16'h0);
    @(negedge clk);
    checkOutput("wr_no_b_rvalid", 32'(if1.b_rvalid), 32'd0);
    checkOutput("wr_not_busy", 32'(if1.busy), 32'd0);

    // Latency 3: A read at t, B request from t+1 is granted in A's free cycle.
    step();
    applyStimulus(1, 1, 0, 24'h000100, 16'h0, 0, 0, 24'h0, 16'h0, 16'hCAFE);
    @(negedge clk);
    checkOutput("l3_a_gnt", 32'(if3.a_gnt), 32'd1);
    step();
    applyStimulus(1, 0, 0, 24'h0, 16'h0, 1, 0, 24'h000200, 16'h0, 16'hCAFE);
    @(negedge clk);
    checkOutput("l3_busy_t1", 32'(if3.busy), 32'd1);
    checkOutput("l3_b_gnt_t1", 32'(if3.b_gnt), 32'd0);
    step();
    @(negedge clk);
    checkOutput("l3_busy_t2", 32'(if3.busy), 32'd1);
    checkOutput("l3_b_gnt_t2", 32'(if3.b_gnt), 32'd0);
    step();
    @(negedge clk);
    checkOutput("l3_a_rvalid_t3", 32'(if3.a_rvalid), 32'd1);
    checkOutput("l3_a_rdata_t3", 32'(if3.a_rdata), 32'h0000CAFE);
    checkOutput("l3_b_gnt_t3", 32'(if3.b_gnt), 32'd1);
    step();
    applyStimulus(1, 0, 0, 24'h0, 16'h0, 0, 0, 24'h0, 16'h0, 16'hCAFE);
    repeat (4) step();

    // Reset in the cycle after a latency-3 read grant discards the read.
    applyStimulus(1, 1, 0, 24'h000300, 16'h0, 0, 0, 24'h0, 16'h0, 16'h7777);
    @(negedge clk);
    checkOutput("mid_a_gnt", 32'(if3.a_gnt), 32'd1);
    step();
    applyStimulus(1, 0, 0, 24'h0, 16'h0, 0, 0, 24'h0, 16'h0, 16'h7777);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_busy", 32'(if3.busy), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("mid_no_rvalid", 32'(if3.a_rvalid), 32'd0);
      step();
    end
    applyStimulus(1, 1, 0, 24'h000400, 16'h0, 0, 0, 24'h0, 16'h0, 16'h5A5A);
    @(negedge clk);
    checkOutput("post_a_gnt", 32'(if3.a_gnt), 32'd1);
    step();
    applyStimulus(1, 0, 0, 24'h0, 16'h0, 0, 0, 24'h0, 16'h0, 16'h5A5A);
    repeat (2) step();
    @(negedge clk);
    checkOutput("post_a_rvalid", 32'(if3.a_rvalid), 32'd1);
    checkOutput("post_a_rdata", 32'(if3.a_rdata), 32'h00005A5A);
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
